// File: rtl/mips_mdu.sv
// Multi-cycle multiply/divide unit for the EX stage; owns the architectural HI/LO registers.
// Results are computed from operands latched on accept and written when the busy countdown expires.
module mips_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned CW = 4;
    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    op_e           op_q,   op_d;
    logic [DW-1:0] a_q,    a_d;
    logic [DW-1:0] b_q,    b_d;
    logic [DW-1:0] hi_q,   hi_d;
    logic [DW-1:0] lo_q,   lo_d;

    logic                 accept;
    op_e                  op_in;
    logic signed [63:0]   mul_s;
    logic        [63:0]   mul_u;
    logic                 a_neg, b_neg;
    logic        [DW-1:0] a_mag, b_mag, b_safe;
    logic        [DW-1:0] q_mag, r_mag, quot, rem;

    assign accept = Start & ~Req & ~busy_q;
    assign op_in  = op_e'(MDUOp);

    // Products over the latched operands only; live A/B may change while busy.
    assign mul_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign mul_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide via magnitudes: quotient truncates toward zero, remainder follows the
    // dividend, and 0x80000000 / -1 falls out as 0x80000000 r 0 without special-casing.
    assign a_neg  = (op_q == OP_DIV) & a_q[31];
    assign b_neg  = (op_q == OP_DIV) & b_q[31];
    assign a_mag  = a_neg ? DW'(-a_q) : a_q;
    assign b_mag  = b_neg ? DW'(-b_q) : b_q;
    assign b_safe = (b_mag == '0) ? DW'(1) : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quot   = (a_neg ^ b_neg) ? DW'(-q_mag) : q_mag;
    assign rem    = a_neg ? DW'(-r_mag) : r_mag;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        hi_d   = hi_q;
        lo_d   = lo_q;

        if (busy_q) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                unique case (op_q)
                    OP_MULT:  {hi_d, lo_d} = mul_s;
                    OP_MULTU: {hi_d, lo_d} = mul_u;
                    OP_DIV, OP_DIVU: begin
                        if (b_q != '0) begin
                            hi_d = rem;
                            lo_d = quot;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (accept) begin
            unique case (op_in)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    busy_d = 1'b1;
                    op_d   = op_in;
                    a_d    = A;
                    b_d    = B;
                    cnt_d  = (op_in == OP_MULT || op_in == OP_MULTU) ?
                             CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= OP_NONE;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mips_mdu.sv
// Directed bench for mips_mdu: a vector table of single operations followed by
// hand-written sequences for reset, Req suppression, operand latching and back-to-back issue.
module tb_mips_mdu;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Req;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int tests;
    int fails;

    mips_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .Req   (Req),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The stall unit never lets Start reach a busy unit.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(Start && Busy)) else $error("FAIL start_while_busy");
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one instruction for a single cycle; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic req);
        @(negedge clk);
        Start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        Req   = req;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = 3'd0;
        Req   = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    // Count busy cycles (bounded), scrambling A/B each cycle; optional Req pulse at cycle 3.
    task automatic wait_busy(input bit req_pulse, output int n);
        n = 0;
        while (Busy && n < 40) begin
            n++;
            A   = $urandom;
            B   = $urandom;
            Req = req_pulse && (n == 3);
            @(negedge clk);
        end
        Req = 1'b0;
    endtask

    initial begin
        int n;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        Start = 1'b0;
        MDUOp = 3'd0;
        A     = '0;
        B     = '0;
        Req   = 1'b0;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{3'd5, 32'h0000_0011, 32'h0000_0000, 32'h0000_0011, 32'hFFFF_FFFD, 0};
        vecs[4]  = '{3'd6, 32'h0000_0022, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 0};
        vecs[5]  = '{3'd4, 32'h0000_0007, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 10};
        vecs[6]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[7]  = '{3'd4, 32'd100,       32'd7,         32'd2,         32'd14,        10};
        vecs[8]  = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};
        vecs[9]  = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[10] = '{3'd0, 32'h5555_5555, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFD, 0};
        vecs[11] = '{3'd7, 32'h5555_5555, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFD, 0};
        vecs[12] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[13] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 5};

        repeat (2) @(negedge clk);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            wait_busy(1'b0, n);
            check($sformatf("vec%0d_busy_cycles", i), 32'(n), 32'(vecs[i].busy));
            check($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
        end

        // Reset two cycles into a mult clears everything at once and nothing lands later.
        issue(3'd1, 32'd3, 32'd5, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", 32'(Busy), 32'd0);
        check("rst_mid_hi", HI, 32'd0);
        check("rst_mid_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_after_busy", 32'(Busy), 32'd0);
        check("rst_after_hi", HI, 32'd0);
        check("rst_after_lo", LO, 32'd0);

        // Req cancels the current-cycle instruction.
        issue(3'd5, 32'h0000_00AB, 32'd0, 1'b0);
        check("mthi_ab", HI, 32'h0000_00AB);
        issue(3'd5, 32'h0000_1234, 32'd0, 1'b1);
        check("mthi_req_hi", HI, 32'h0000_00AB);
        issue(3'd5, 32'h0000_1234, 32'd0, 1'b0);
        check("mthi_hi", HI, 32'h0000_1234);
        check("mthi_busy", 32'(Busy), 32'd0);
        issue(3'd1, 32'd3, 32'd5, 1'b1);
        check("mult_req_busy", 32'(Busy), 32'd0);
        repeat (6) @(negedge clk);
        check("mult_req_lo", LO, 32'd0);

        // div with scrambled live operands and a Req pulse mid-flight: 1000 / -7.
        issue(3'd3, 32'd1000, 32'hFFFF_FFF9, 1'b0);
        wait_busy(1'b1, n);
        check("divreq_busy_cycles", 32'(n), 32'd10);
        check("divreq_lo", LO, 32'hFFFF_FF72);
        check("divreq_hi", HI, 32'h0000_0006);

        // Back-to-back: divu presented in the first cycle Busy is low after a mult.
        issue(3'd1, 32'd6, 32'd7, 1'b0);
        wait_busy(1'b0, n);
        check("b2b_mult_cycles", 32'(n), 32'd5);
        check("b2b_mult_lo", LO, 32'd42);
        check("b2b_mult_hi", HI, 32'd0);
        Start = 1'b1;
        MDUOp = 3'd4;
        A     = 32'd100;
        B     = 32'd7;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = 3'd0;
        check("b2b_div_busy", 32'(Busy), 32'd1);
        check("b2b_hold_lo", LO, 32'd42);
        wait_busy(1'b0, n);
        check("b2b_div_cycles", 32'(n), 32'd10);
        check("b2b_div_lo", LO, 32'd14);
        check("b2b_div_hi", HI, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
